// File: rtl/struct_array_pkg.sv
// Shared element layout for the struct-array packer/unpacker pair.
// Slot i of a packed word sits at bit slot_lsb(i); inside a slot a is MSB-most, c LSB-most.
package struct_array_pkg;

   localparam int A_W_DEFAULT = 1;
   localparam int B_W_DEFAULT = 4;
   localparam int C_W_DEFAULT = 2;
   localparam int ELEM_W      = A_W_DEFAULT + B_W_DEFAULT + C_W_DEFAULT;
   localparam int N_DEFAULT   = 8;

   typedef struct packed {
      logic [A_W_DEFAULT-1:0] a;
      logic [B_W_DEFAULT-1:0] b;
      logic [C_W_DEFAULT-1:0] c;
   } elem_t;

   function automatic int unsigned slot_lsb(input int unsigned i, input int unsigned ew = ELEM_W);
      return i * ew;
   endfunction

endpackage

// File: rtl/struct_array_packer.sv
// Packs N {a,b,c} elements into one word; STRUCT_PACKER_FLUSH_EN adds flush/out_count.
// Latency: out_valid rises on the edge that accepts the N-th element (or a flush).
// Backpressure: in_ready = !out_valid || out_ready, so a drain and a new accept share an edge.
module struct_array_packer
   import struct_array_pkg::*;
#(
   parameter int N   = N_DEFAULT,
   parameter int A_W = A_W_DEFAULT,
   parameter int B_W = B_W_DEFAULT,
   parameter int C_W = C_W_DEFAULT,
   localparam int SLOT_W = A_W + B_W + C_W,
   localparam int WORD_W = N * SLOT_W,
   localparam int CNT_W  = $clog2(N + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [A_W-1:0]    in_a,
   input  logic [B_W-1:0]    in_b,
   input  logic [C_W-1:0]    in_c,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_word
`ifdef STRUCT_PACKER_FLUSH_EN
   ,
   input  logic              flush,
   output logic [CNT_W-1:0]  out_count
`endif
);

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [WORD_W-1:0] word_nxt;
   logic              valid_nxt;
   logic              accept;
   logic              drain;
   logic              complete;
   logic [SLOT_W-1:0] elem;

   assign elem     = {in_a, in_b, in_c};
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready;
   assign complete = accept && (cnt == CNT_W'(N - 1));

`ifdef STRUCT_PACKER_FLUSH_EN
   logic [CNT_W-1:0] filled;
   logic             fire;

   // Slots occupied once this cycle's accept (if any) has landed.
   assign filled = accept ? cnt + CNT_W'(1) : cnt;
   assign fire   = flush && in_ready && !complete && (filled != '0);
`endif

   always_comb begin
      word_nxt = out_word;
      cnt_nxt  = cnt;
      if (accept) begin
         // A fresh word starts from zero so stale slots never leak forward.
         if (cnt == '0) begin
            word_nxt = '0;
         end
         for (int i = 0; i < N; i++) begin
            if (cnt == CNT_W'(i)) begin
               word_nxt[slot_lsb(i, SLOT_W) +: SLOT_W] = elem;
            end
         end
         cnt_nxt = complete ? '0 : cnt + CNT_W'(1);
      end
`ifdef STRUCT_PACKER_FLUSH_EN
      if (fire) begin
         cnt_nxt = '0;
      end
`endif
   end

   always_comb begin
      valid_nxt = out_valid;
      if (drain) begin
         valid_nxt = 1'b0;
      end
      if (complete) begin
         valid_nxt = 1'b1;
      end
`ifdef STRUCT_PACKER_FLUSH_EN
      if (fire) begin
         valid_nxt = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         out_word  <= '0;
         out_valid <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         out_word  <= word_nxt;
         out_valid <= valid_nxt;
      end
   end

`ifdef STRUCT_PACKER_FLUSH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_count <= '0;
      end else if (complete) begin
         out_count <= CNT_W'(N);
      end else if (fire) begin
         out_count <= filled;
      end
   end
`endif

endmodule

// File: tb/tb_struct_array_packer.sv
// Bench for struct_array_packer: directed layout checks plus a randomized scoreboard run.
// Flush checks are compiled in when STRUCT_PACKER_FLUSH_EN is defined.
module tb_struct_array_packer;
   import struct_array_pkg::*;

   localparam int N     = N_DEFAULT;
   localparam int W     = N * ELEM_W;
   localparam int CNT_W = $clog2(N + 1);

   localparam logic [ELEM_W-1:0] KNOWN [N] = '{7'h28, 7'h73, 7'h22, 7'h39, 7'h1F, 7'h5F, 7'h5B, 7'h3D};
   localparam logic [W-1:0] KNOWN_WORD = 56'h7B6EF9F728B9A8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [0:0]       in_a;
   logic [3:0]       in_b;
   logic [1:0]       in_c;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_word;
`ifdef STRUCT_PACKER_FLUSH_EN
   logic             flush;
   logic [CNT_W-1:0] out_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   struct_array_packer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word)
`ifdef STRUCT_PACKER_FLUSH_EN
      ,
      .flush     (flush),
      .out_count (out_count)
`endif
   );

   // Reference packing: element k of the list lands at bit k*ELEM_W, others zero.
   function automatic logic [W-1:0] pack(input logic [ELEM_W-1:0] e [$]);
      logic [W-1:0] w;
      logic [W-1:0] t;
      w = '0;
      foreach (e[k]) begin
         t = '0;
         t[ELEM_W-1:0] = e[k];
         w = w | (t << (k * ELEM_W));
      end
      return w;
   endfunction

   function automatic logic [ELEM_W-1:0] rand_elem();
      return ELEM_W'($urandom);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [ELEM_W-1:0] e, input logic v);
      elem_t s;
      s        = e;
      in_valid = v;
      in_a     = s.a;
      in_b     = s.b;
      in_c     = s.c;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive('0, 1'b0);
`ifdef STRUCT_PACKER_FLUSH_EN
      flush = 1'b0;
`endif
      step();
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (out_word !== '0) begin
         errors++; $display("FAIL reset_out_word: got %h want 0", out_word);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
`ifdef STRUCT_PACKER_FLUSH_EN
      checks++;
      if (out_count !== '0) begin
         errors++; $display("FAIL reset_out_count: got %0d want 0", out_count);
      end
`endif
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_known_word();
      logic [ELEM_W-1:0] q [$];
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         drive(KNOWN[i], 1'b1);
         q.push_back(KNOWN[i]);
         step();
         if (i == N - 2) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++; $display("FAIL known_early_valid: got %b want 0 after %0d accepts", out_valid, N - 1);
            end
         end
      end
      drive('0, 1'b0);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL known_valid: got %b want 1", out_valid);
      end
      checks++;
      if (out_word !== KNOWN_WORD) begin
         errors++; $display("FAIL known_word: got %h want %h", out_word, KNOWN_WORD);
      end
      checks++;
      if (out_word !== pack(q)) begin
         errors++; $display("FAIL known_model: got %h want %h", out_word, pack(q));
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (out_word[i*ELEM_W +: ELEM_W] !== KNOWN[i]) begin
            errors++; $display("FAIL known_unpack_slot%0d: got %h want %h", i, out_word[i*ELEM_W +: ELEM_W], KNOWN[i]);
         end
      end
`ifdef STRUCT_PACKER_FLUSH_EN
      checks++;
      if (out_count !== CNT_W'(N)) begin
         errors++; $display("FAIL known_out_count: got %0d want %0d", out_count, N);
      end
`endif
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL known_drain: got %b want 0", out_valid);
      end
   endtask

   task automatic test_stall_and_overlap();
      logic [ELEM_W-1:0] q [$];
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         drive(KNOWN[i], 1'b1);
         step();
      end
      // Keep offering an element that must not be taken during the stall.
      drive(7'h2A, 1'b1);
      for (int c = 0; c < 5; c++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_word !== KNOWN_WORD) begin
            errors++;
            $display("FAIL stall_cycle%0d: valid=%b ready=%b word=%h want 1 0 %h", c, out_valid, in_ready, out_word, KNOWN_WORD);
         end
      end
      out_ready = 1'b1;
      drive(7'h7F, 1'b1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready);
      end
      step();
      q.push_back(7'h7F);
      drive('0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || out_word !== 56'h7F) begin
         errors++; $display("FAIL overlap_slot0: valid=%b word=%h want 0 %h", out_valid, out_word, 56'h7F);
      end
      for (int i = 1; i < N; i++) begin
         q.push_back(rand_elem());
         drive(q[i], 1'b1);
         step();
      end
      drive('0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_word !== pack(q)) begin
         errors++; $display("FAIL overlap_word: valid=%b word=%h want 1 %h", out_valid, out_word, pack(q));
      end
      step();
   endtask

   task automatic test_async_reset();
      logic [ELEM_W-1:0] q [$];
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive((i == 0) ? 7'h55 : rand_elem(), 1'b1);
         step();
      end
      drive('0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_word !== '0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL async_reset: valid=%b word=%h ready=%b want 0 0 1", out_valid, out_word, in_ready);
      end
      #3;
      rst_n = 1'b1;
      step();
      for (int i = 0; i < N; i++) begin
         q.push_back(rand_elem());
         drive(q[i], 1'b1);
         step();
      end
      drive('0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_word !== pack(q)) begin
         errors++; $display("FAIL post_reset_word: valid=%b word=%h want 1 %h", out_valid, out_word, pack(q));
      end
      step();
   endtask

   task automatic test_toggle_scoreboard();
      logic [ELEM_W-1:0] data [16];
      logic [ELEM_W-1:0] acc [$];
      logic [W-1:0]      exp_words [$];
      logic [W-1:0]      want;
      int idx   = 0;
      int words = 0;
      int cyc   = 0;
      foreach (data[k]) data[k] = rand_elem();
      while (!(idx == 16 && words == 2) && cyc < 400) begin
         drive(data[idx % 16], (cyc % 2 == 0) && (idx < 16));
         out_ready = 1'($urandom_range(0, 1));
         #2;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_words.size() == 0) begin
               errors++; $display("FAIL toggle_extra_word: got %h with nothing expected", out_word);
            end else begin
               want = exp_words.pop_front();
               if (out_word !== want) begin
                  errors++; $display("FAIL toggle_word%0d: got %h want %h", words, out_word, want);
               end
            end
            words++;
         end
         if (in_valid && in_ready) begin
            acc.push_back(data[idx]);
            idx++;
            if (acc.size() == N) begin
               exp_words.push_back(pack(acc));
               acc.delete();
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      drive('0, 1'b0);
      checks++;
      if (idx != 16 || words != 2) begin
         errors++; $display("FAIL toggle_count: accepted=%0d words=%0d want 16 2 (cycles %0d)", idx, words, cyc);
      end
      out_ready = 1'b1;
      step();
   endtask

`ifdef STRUCT_PACKER_FLUSH_EN
   task automatic test_flush();
      logic [ELEM_W-1:0] q [$];
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         q.push_back(rand_elem());
         drive(q[i], 1'b1);
         step();
      end
      drive('0, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_count !== CNT_W'(3) || out_word !== pack(q)) begin
         errors++;
         $display("FAIL flush_partial: valid=%b count=%0d word=%h want 1 3 %h", out_valid, out_count, out_word, pack(q));
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_drain: got %b want 0", out_valid);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_empty: got %b want 0", out_valid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_known_word();
      test_stall_and_overlap();
      test_async_reset();
      test_toggle_scoreboard();
`ifdef STRUCT_PACKER_FLUSH_EN
      test_flush();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
